// File: rtl/port_ingress_buffer.sv
// Per-port ingress buffer: accepts packets from one switch port, stores
// complete packets in a word FIFO with a descriptor queue, and streams one
// whole packet to the SRAM write side after each arbiter grant.
//
// Handshake: a packet word is taken on every cycle wr_vld is high (there is
// no back-pressure). xfer_req is held while a committed packet waits and TX
// is idle. A one-cycle xfer_grant seen while xfer_req is high starts a
// transfer. wr_xfer_data_vld then marks exactly xfer_length contiguous
// words, which are followed by a single wr_end_of_packet cycle.
module port_ingress_buffer #(
  parameter int DATA_DEPTH = 64,
  parameter int PKT_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_sop,
  input  logic                        wr_vld,
  input  logic [15:0]                 wr_data,
  input  logic                        wr_eop,
  output logic                        xfer_req,
  output logic [3:0]                  xfer_dest_port,
  output logic [8:0]                  xfer_length,
  input  logic                        xfer_grant,
  output logic                        wr_xfer_data_vld,
  output logic [15:0]                 wr_xfer_data,
  output logic                        wr_end_of_packet,
  output logic [$clog2(DATA_DEPTH):0] buf_words_used,
  output logic [15:0]                 drop_count
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PKT_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DISCARD} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_READ, TX_EOP} tx_state_t;

  // Storage
  logic [15:0]   mem [DATA_DEPTH];
  logic [AW-1:0] desc_start [PKT_DEPTH];
  logic [CW-1:0] desc_len   [PKT_DEPTH];
  logic [3:0]    desc_dest  [PKT_DEPTH];

  // RX state
  rx_state_t     rx_state_q, rx_state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] start_ptr_q, start_ptr_d;
  logic [CW-1:0] inprog_q, inprog_d;
  logic [8:0]    hdr_len_q, hdr_len_d;
  logic [3:0]    hdr_dest_q, hdr_dest_d;
  logic [CW-1:0] committed_q, committed_d;
  logic [15:0]   drop_q, drop_d;

  // Descriptor queue
  logic [PW-1:0] dq_wr_q, dq_rd_q;
  logic [PW:0]   dq_cnt_q;
  logic          dq_full;

  // TX state
  tx_state_t     tx_state_q, tx_state_d;
  logic [AW-1:0] tx_addr_q, tx_addr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          vld_q, vld_d;
  logic          eop_q, eop_d;
  logic [15:0]   data_q;

  // Combinational controls
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          push;
  logic [AW-1:0] push_start;
  logic [CW-1:0] push_len;
  logic [3:0]    push_dest;
  logic [1:0]    drop_inc;
  logic [AW-1:0] base_ptr;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] used;
  logic          rd_en;
  logic          pop;
  logic [AW-1:0] head_start;
  logic [CW-1:0] head_len;
  logic [16:0]   drop_sum;

  assign dq_full    = (dq_cnt_q == (PW+1)'(PKT_DEPTH));
  assign used       = committed_q + inprog_q;
  assign head_start = desc_start[dq_rd_q];
  assign head_len   = desc_len[dq_rd_q];

  // The eop_q term keeps xfer_req low during the end-of-packet cycle itself.
  assign xfer_req         = (dq_cnt_q != '0) && (tx_state_q == TX_IDLE) && !eop_q;
  assign xfer_dest_port   = xfer_req ? desc_dest[dq_rd_q] : 4'd0;
  assign xfer_length      = xfer_req ? 9'(head_len) : 9'd0;
  assign wr_xfer_data_vld = vld_q;
  assign wr_xfer_data     = data_q;
  assign wr_end_of_packet = eop_q;
  assign buf_words_used   = used;
  assign drop_count       = drop_q;

  // RX next-state: header capture, word writes, commit and drop decisions.
  // A sop in RECV abandons the partial packet, so the new header reuses its
  // start pointer and only committed words count against space.
  always_comb begin
    rx_state_d  = rx_state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    inprog_d    = inprog_q;
    hdr_len_d   = hdr_len_q;
    hdr_dest_d  = hdr_dest_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
    push        = 1'b0;
    push_start  = start_ptr_q;
    push_len    = '0;
    push_dest   = hdr_dest_q;
    drop_inc    = 2'd0;
    base_ptr    = (rx_state_q == RX_RECV) ? start_ptr_q : wr_ptr_q;
    cnt_next    = inprog_q + 1'b1;
    if (wr_vld) begin
      if (wr_sop) begin
        if (rx_state_q == RX_RECV) drop_inc = 2'd1;
        wr_ptr_d = base_ptr;
        inprog_d = '0;
        if (dq_full || (committed_q >= CW'(DATA_DEPTH))) begin
          drop_inc   = drop_inc + 2'd1;
          rx_state_d = wr_eop ? RX_IDLE : RX_DISCARD;
        end else begin
          mem_we      = 1'b1;
          mem_waddr   = base_ptr;
          start_ptr_d = base_ptr;
          hdr_len_d   = wr_data[15:7];
          hdr_dest_d  = wr_data[3:0];
          if (wr_eop) begin
            rx_state_d = RX_IDLE;
            if (wr_data[15:7] == 9'd1) begin
              push       = 1'b1;
              push_start = base_ptr;
              push_len   = CW'(1);
              push_dest  = wr_data[3:0];
              wr_ptr_d   = base_ptr + 1'b1;
            end else begin
              drop_inc = drop_inc + 2'd1;
            end
          end else begin
            rx_state_d = RX_RECV;
            wr_ptr_d   = base_ptr + 1'b1;
            inprog_d   = CW'(1);
          end
        end
      end else if (rx_state_q == RX_RECV) begin
        if (used >= CW'(DATA_DEPTH)) begin
          drop_inc   = 2'd1;
          wr_ptr_d   = start_ptr_q;
          inprog_d   = '0;
          rx_state_d = wr_eop ? RX_IDLE : RX_DISCARD;
        end else begin
          mem_we = 1'b1;
          if (wr_eop) begin
            rx_state_d = RX_IDLE;
            inprog_d   = '0;
            if (9'(cnt_next) == hdr_len_q) begin
              push     = 1'b1;
              push_len = cnt_next;
              wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
              drop_inc = 2'd1;
              wr_ptr_d = start_ptr_q;
            end
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            inprog_d = cnt_next;
          end
        end
      end else if ((rx_state_q == RX_DISCARD) && wr_eop) begin
        rx_state_d = RX_IDLE;
      end
    end
  end

  // TX next-state: one read per READ cycle, then a single EOP cycle that
  // pops the descriptor and frees its words.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_addr_d  = tx_addr_q;
    tx_cnt_d   = tx_cnt_q;
    rd_en      = 1'b0;
    pop        = 1'b0;
    vld_d      = 1'b0;
    eop_d      = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (xfer_grant && xfer_req) begin
          tx_state_d = TX_READ;
          tx_addr_d  = head_start;
          tx_cnt_d   = '0;
        end
      end
      TX_READ: begin
        rd_en     = 1'b1;
        vld_d     = 1'b1;
        tx_addr_d = tx_addr_q + 1'b1;
        tx_cnt_d  = tx_cnt_q + 1'b1;
        if (CW'(tx_cnt_q + 1'b1) == head_len) tx_state_d = TX_EOP;
      end
      TX_EOP: begin
        eop_d      = 1'b1;
        pop        = 1'b1;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Shared bookkeeping: committed words and saturating drop counter.
  always_comb begin
    committed_d = committed_q + (push ? push_len : '0) - (pop ? head_len : '0);
    drop_sum    = {1'b0, drop_q} + {15'd0, drop_inc};
    drop_d      = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= RX_IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      inprog_q    <= '0;
      hdr_len_q   <= '0;
      hdr_dest_q  <= '0;
      committed_q <= '0;
      drop_q      <= '0;
      dq_wr_q     <= '0;
      dq_rd_q     <= '0;
      dq_cnt_q    <= '0;
      tx_state_q  <= TX_IDLE;
      tx_addr_q   <= '0;
      tx_cnt_q    <= '0;
      vld_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      inprog_q    <= inprog_d;
      hdr_len_q   <= hdr_len_d;
      hdr_dest_q  <= hdr_dest_d;
      committed_q <= committed_d;
      drop_q      <= drop_d;
      if (push) dq_wr_q <= dq_wr_q + 1'b1;
      if (pop)  dq_rd_q <= dq_rd_q + 1'b1;
      dq_cnt_q    <= dq_cnt_q + (push ? 1'b1 : 1'b0) - (pop ? 1'b1 : 1'b0);
      tx_state_q  <= tx_state_d;
      tx_addr_q   <= tx_addr_d;
      tx_cnt_q    <= tx_cnt_d;
      vld_q       <= vld_d;
      eop_q       <= eop_d;
      if (rd_en) data_q <= mem[tx_addr_q];
    end
  end

  // Word and descriptor storage; contents are don't-care until committed.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= wr_data;
    if (push) begin
      desc_start[dq_wr_q] <= push_start;
      desc_len[dq_wr_q]   <= push_len;
      desc_dest[dq_wr_q]  <= push_dest;
    end
  end

endmodule

// File: tb/tb_port_ingress_buffer.sv
// Directed bench for port_ingress_buffer: packets in, grants, and word-exact
// checks of the transfer bus against an expected-word queue.
module tb_port_ingress_buffer;

  logic        clk;
  logic        rst;
  logic        wr_sop;
  logic        wr_vld;
  logic [15:0] wr_data;
  logic        wr_eop;
  logic        xfer_req;
  logic [3:0]  xfer_dest_port;
  logic [8:0]  xfer_length;
  logic        xfer_grant;
  logic        wr_xfer_data_vld;
  logic [15:0] wr_xfer_data;
  logic        wr_end_of_packet;
  logic [6:0]  buf_words_used;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] pkt_buf [128];

  port_ingress_buffer #(.DATA_DEPTH(64), .PKT_DEPTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_sop           (wr_sop),
    .wr_vld           (wr_vld),
    .wr_data          (wr_data),
    .wr_eop           (wr_eop),
    .xfer_req         (xfer_req),
    .xfer_dest_port   (xfer_dest_port),
    .xfer_length      (xfer_length),
    .xfer_grant       (xfer_grant),
    .wr_xfer_data_vld (wr_xfer_data_vld),
    .wr_xfer_data     (wr_xfer_data),
    .wr_end_of_packet (wr_end_of_packet),
    .buf_words_used   (buf_words_used),
    .drop_count       (drop_count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Fill pkt_buf with a header and patterned payload; optionally expect it out.
  task automatic load_pkt(input logic [15:0] hdr, input int n, input bit expect_out);
    pkt_buf[0] = hdr;
    for (int i = 1; i < n; i++) pkt_buf[i] = {hdr[7:0] ^ 8'h5A, 8'(i)};
    if (expect_out) for (int i = 0; i < n; i++) exp_q.push_back(pkt_buf[i]);
  endtask

  // Drive pkt_buf[0..n-1] one word per cycle.
  task automatic send_words(input int n, input bit with_sop, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      wr_vld  = 1'b1;
      wr_sop  = with_sop && (i == 0);
      wr_eop  = with_eop && (i == n - 1);
      wr_data = pkt_buf[i];
      tick();
    end
    wr_vld = 1'b0;
    wr_sop = 1'b0;
    wr_eop = 1'b0;
  endtask

  // Grant the head packet and check request, data words and end pulse timing.
  task automatic do_xfer(input int len, input logic [3:0] dest, input bit exp_req_after);
    logic [15:0] exp_w;
    check_eq("req_before_grant", 32'(xfer_req), 32'd1);
    check_eq("dest_before_grant", 32'(xfer_dest_port), 32'(dest));
    check_eq("len_before_grant", 32'(xfer_length), 32'(len));
    xfer_grant = 1'b1;
    tick();
    xfer_grant = 1'b0;
    check_eq("req_after_grant", 32'(xfer_req), 32'd0);
    check_eq("vld_grant_plus1", 32'(wr_xfer_data_vld), 32'd0);
    for (int i = 0; i < len; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
        exp_w = 16'h0000;
      end else begin
        exp_w = exp_q.pop_front();
      end
      check_eq("xfer_vld", 32'(wr_xfer_data_vld), 32'd1);
      check_eq("xfer_data", 32'(wr_xfer_data), 32'(exp_w));
      check_eq("xfer_eop_early", 32'(wr_end_of_packet), 32'd0);
    end
    tick();
    check_eq("eop_pulse", 32'(wr_end_of_packet), 32'd1);
    check_eq("vld_in_eop", 32'(wr_xfer_data_vld), 32'd0);
    check_eq("req_in_eop", 32'(xfer_req), 32'd0);
    tick();
    check_eq("eop_one_cycle", 32'(wr_end_of_packet), 32'd0);
    check_eq("req_after_eop", 32'(xfer_req), 32'(exp_req_after));
  endtask

  initial begin
    rst        = 1'b1;
    wr_sop     = 1'b0;
    wr_vld     = 1'b0;
    wr_data    = 16'h0000;
    wr_eop     = 1'b0;
    xfer_grant = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_req", 32'(xfer_req), 32'd0);
    check_eq("rst_vld", 32'(wr_xfer_data_vld), 32'd0);
    check_eq("rst_data", 32'(wr_xfer_data), 32'd0);
    check_eq("rst_eop", 32'(wr_end_of_packet), 32'd0);
    check_eq("rst_used", 32'(buf_words_used), 32'd0);
    check_eq("rst_drops", 32'(drop_count), 32'd0);
    check_eq("rst_dest", 32'(xfer_dest_port), 32'd0);
    check_eq("rst_len", 32'(xfer_length), 32'd0);

    // Single packet: length 3, dest 3
    load_pkt(16'h0183, 3, 1'b1);
    send_words(3, 1'b1, 1'b1);
    check_eq("single_used", 32'(buf_words_used), 32'd3);
    do_xfer(3, 4'd3, 1'b0);
    check_eq("single_used_after", 32'(buf_words_used), 32'd0);

    // Back-to-back: lengths 4 (dest 5) and 2 (dest 9)
    load_pkt(16'h0205, 4, 1'b1);
    send_words(4, 1'b1, 1'b1);
    load_pkt(16'h0109, 2, 1'b1);
    send_words(2, 1'b1, 1'b1);
    check_eq("b2b_used", 32'(buf_words_used), 32'd6);
    do_xfer(4, 4'd5, 1'b1);
    check_eq("b2b_used_mid", 32'(buf_words_used), 32'd2);
    do_xfer(2, 4'd9, 1'b0);
    check_eq("b2b_used_after", 32'(buf_words_used), 32'd0);

    // Overflow: header length 70 exceeds 64-word FIFO
    load_pkt(16'h2301, 70, 1'b0);
    send_words(64, 1'b1, 1'b0);
    check_eq("ovf_used_full", 32'(buf_words_used), 32'd64);
    send_words(6, 1'b0, 1'b1);
    check_eq("ovf_drops", 32'(drop_count), 32'd1);
    check_eq("ovf_req", 32'(xfer_req), 32'd0);
    check_eq("ovf_used", 32'(buf_words_used), 32'd0);
    load_pkt(16'h0102, 2, 1'b1);
    send_words(2, 1'b1, 1'b1);
    do_xfer(2, 4'd2, 1'b0);

    // Length mismatch: header 5, eop on word 4
    load_pkt(16'h0284, 4, 1'b0);
    send_words(4, 1'b1, 1'b1);
    check_eq("mis_drops", 32'(drop_count), 32'd2);
    check_eq("mis_req", 32'(xfer_req), 32'd0);
    check_eq("mis_used", 32'(buf_words_used), 32'd0);

    // sop mid-packet drops the partial packet and starts a new one
    load_pkt(16'h0187, 3, 1'b0);
    send_words(2, 1'b1, 1'b0);
    check_eq("mid_used_partial", 32'(buf_words_used), 32'd2);
    load_pkt(16'h0106, 2, 1'b1);
    send_words(2, 1'b1, 1'b1);
    check_eq("mid_drops", 32'(drop_count), 32'd3);
    check_eq("mid_used", 32'(buf_words_used), 32'd2);
    do_xfer(2, 4'd6, 1'b0);

    // Concurrency: 10-word packet in while 8-word packet streams out
    load_pkt(16'h0408, 8, 1'b1);
    send_words(8, 1'b1, 1'b1);
    check_eq("conc_used_first", 32'(buf_words_used), 32'd8);
    load_pkt(16'h050A, 10, 1'b1);
    fork
      do_xfer(8, 4'd8, 1'b1);
      send_words(10, 1'b1, 1'b1);
    join
    check_eq("conc_used_second", 32'(buf_words_used), 32'd10);
    check_eq("conc_drops", 32'(drop_count), 32'd3);
    do_xfer(10, 4'd10, 1'b0);
    check_eq("conc_used_after", 32'(buf_words_used), 32'd0);

    // Descriptor queue full: eight 1-word packets, ninth sop dropped
    for (int k = 0; k < 8; k++) begin
      load_pkt(16'h0080 | 16'(k), 1, 1'b1);
      send_words(1, 1'b1, 1'b1);
    end
    check_eq("dq_used", 32'(buf_words_used), 32'd8);
    load_pkt(16'h0089, 1, 1'b0);
    send_words(1, 1'b1, 1'b1);
    check_eq("dq_full_drops", 32'(drop_count), 32'd4);
    check_eq("dq_full_used", 32'(buf_words_used), 32'd8);
    for (int k = 0; k < 8; k++) do_xfer(1, 4'(k), k < 7);
    check_eq("dq_used_after", 32'(buf_words_used), 32'd0);

    // Reset at transfer word 3 with another packet queued
    load_pkt(16'h0281, 5, 1'b0);
    send_words(5, 1'b1, 1'b1);
    load_pkt(16'h0102, 2, 1'b0);
    send_words(2, 1'b1, 1'b1);
    check_eq("rst2_req_pre", 32'(xfer_req), 32'd1);
    xfer_grant = 1'b1;
    tick();
    xfer_grant = 1'b0;
    tick();
    tick();
    tick();
    check_eq("rst2_word3_vld", 32'(wr_xfer_data_vld), 32'd1);
    check_eq("rst2_word3_data", 32'(wr_xfer_data), 32'h00DB02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_vld", 32'(wr_xfer_data_vld), 32'd0);
    check_eq("rst2_data", 32'(wr_xfer_data), 32'd0);
    check_eq("rst2_eop", 32'(wr_end_of_packet), 32'd0);
    check_eq("rst2_req", 32'(xfer_req), 32'd0);
    check_eq("rst2_drops", 32'(drop_count), 32'd0);
    check_eq("rst2_used", 32'(buf_words_used), 32'd0);
    tick();
    check_eq("rst2_req_later", 32'(xfer_req), 32'd0);
    check_eq("rst2_eop_later", 32'(wr_end_of_packet), 32'd0);

    // Recovery after reset
    load_pkt(16'h0083, 1, 1'b1);
    send_words(1, 1'b1, 1'b1);
    do_xfer(1, 4'd3, 1'b0);
    check_eq("sb_empty_end", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
